converter_sequencer: RTL

Start-up, run and fault sequencer for the DC-DC power stage. It sits between the system controller and the PWM generator. It drives the generator's enable, shutdown and soft-start controls, and gates the MPPT tracker through its own enable. It monitors input voltage, output voltage, input current and an external fault line. On a fault it shuts the stage down, retries after a backoff, and locks out after repeated failures.

---
 rtl/mppt_pkg.sv | 22 ++
 rtl/fault_detector.sv | 37 +++
 rtl/converter_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mppt_pkg.sv
// Shared encodings for the DC-DC converter control blocks: sequencer states,
// fault cause codes and a small saturating-increment helper.
package mppt_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRECHECK  = 3'd1;
  localparam logic [2:0] ST_SOFTSTART = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_BACKOFF   = 3'd4;
  localparam logic [2:0] ST_LOCKOUT   = 3'd5;

  localparam logic [2:0] FAULT_NONE = 3'd0;
  localparam logic [2:0] FAULT_EXT  = 3'd1;
  localparam logic [2:0] FAULT_OC   = 3'd2;
  localparam logic [2:0] FAULT_OV   = 3'd3;
  localparam logic [2:0] FAULT_UV   = 3'd4;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

endpackage

// File: rtl/fault_detector.sv
// Combinational threshold compares with fixed priority EXT > OC > OV > UV.
// UV only counts when uv_en is high (converter switching).
module fault_detector
  import mppt_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         ext_fault,
  input  logic                         uv_en,
  input  logic signed [DATA_WIDTH-1:0] v_in,
  input  logic signed [DATA_WIDTH-1:0] v_out,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] v_in_min,
  input  logic signed [DATA_WIDTH-1:0] v_out_max,
  input  logic signed [DATA_WIDTH-1:0] i_max,
  output logic                         fault,
  output logic [2:0]                   code
);

  // Priority encode the active fault cause.
  always_comb begin
    code = FAULT_NONE;
    if (ext_fault) begin
      code = FAULT_EXT;
    end else if (i_in > i_max) begin
      code = FAULT_OC;
    end else if (v_out > v_out_max) begin
      code = FAULT_OV;
    end else if (uv_en && (v_in < v_in_min)) begin
      code = FAULT_UV;
    end else begin
      code = FAULT_NONE;
    end
    fault = (code != FAULT_NONE);
  end

endmodule

// File: rtl/converter_sequencer.sv
// Start-up / run / fault sequencer for the DC-DC stage. One shared cycle counter
// times precharge, soft-start, backoff and the stable-RUN retry clear.
module converter_sequencer
  import mppt_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int PRECHARGE_CYCLES = 50_000,
  parameter int SOFTSTART_CYCLES = 1_000_000,
  parameter int RETRY_CYCLES     = 5_000_000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run_req,
  input  logic                         fault_clear,
  input  logic                         ext_fault,
  input  logic signed [DATA_WIDTH-1:0] v_in,
  input  logic signed [DATA_WIDTH-1:0] v_out,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] v_in_min,
  input  logic signed [DATA_WIDTH-1:0] v_out_max,
  input  logic signed [DATA_WIDTH-1:0] i_max,
  output logic                         pwm_enable,
  output logic                         pwm_shutdown,
  output logic                         soft_start_enable,
  output logic                         mppt_enable,
  output logic [2:0]                   state,
  output logic [2:0]                   fault_code,
  output logic [2:0]                   retry_count
);

  localparam logic [31:0] PRE_LAST   = 32'(PRECHARGE_CYCLES - 1);
  localparam logic [31:0] SS_LAST    = 32'(SOFTSTART_CYCLES - 1);
  localparam logic [31:0] RETRY_LAST = 32'(RETRY_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIM  = 3'(MAX_RETRIES);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc_s;
  logic [2:0]  retry_q, retry_d;
  logic [2:0]  code_q, code_d;
  logic        pwm_en_q, pwm_en_d;
  logic        pwm_sd_q, pwm_sd_d;
  logic        ss_en_q, ss_en_d;
  logic        mppt_en_q, mppt_en_d;
  logic        uv_en_s, fault_s, vin_ok_s;
  logic [2:0]  fcode_s;

  assign uv_en_s   = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
  assign vin_ok_s  = (v_in >= v_in_min);
  assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  fault_detector #(.DATA_WIDTH(DATA_WIDTH)) u_fault_detector (
    .ext_fault (ext_fault),
    .uv_en     (uv_en_s),
    .v_in      (v_in),
    .v_out     (v_out),
    .i_in      (i_in),
    .v_in_min  (v_in_min),
    .v_out_max (v_out_max),
    .i_max     (i_max),
    .fault     (fault_s),
    .code      (fcode_s)
  );

  // Next state, counter, retry and fault-code bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc_s;
    retry_d = retry_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (run_req) state_d = ST_PRECHECK;
        else         state_d = ST_IDLE;
      end
      ST_PRECHECK, ST_SOFTSTART, ST_RUN: begin
        // A fault outranks both run_req dropping and a timer completing.
        if (fault_s) begin
          state_d = ST_BACKOFF;
          code_d  = fcode_s;
          retry_d = sat_inc3(retry_q);
        end else if (!run_req) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_PRECHECK) begin
          if (!vin_ok_s)              cnt_d   = 32'd0;
          else if (cnt_q == PRE_LAST) state_d = ST_SOFTSTART;
          else                        state_d = ST_PRECHECK;
        end else if (state_q == ST_SOFTSTART) begin
          if (cnt_q == SS_LAST) state_d = ST_RUN;
          else                  state_d = ST_SOFTSTART;
        end else begin
          if (cnt_q == RETRY_LAST) retry_d = 3'd0;
          else                     retry_d = retry_q;
        end
      end
      ST_BACKOFF: begin
        if (cnt_q == RETRY_LAST) begin
          if (retry_q >= RETRY_LIM) begin
            state_d = ST_LOCKOUT;
          end else if (run_req) begin
            state_d = ST_PRECHECK;
          end else begin
            state_d = ST_IDLE;
            retry_d = 3'd0;
          end
        end else begin
          state_d = ST_BACKOFF;
        end
      end
      ST_LOCKOUT: begin
        if (fault_clear) begin
          state_d = ST_IDLE;
          retry_d = 3'd0;
          code_d  = FAULT_NONE;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = 32'd0;
    else                    cnt_d = cnt_d;
  end

  // Power-stage control decode from the next state.
  always_comb begin
    pwm_en_d  = 1'b0;
    pwm_sd_d  = 1'b1;
    ss_en_d   = 1'b0;
    mppt_en_d = 1'b0;
    case (state_d)
      ST_SOFTSTART: begin
        pwm_en_d = 1'b1;
        pwm_sd_d = 1'b0;
        ss_en_d  = 1'b1;
      end
      ST_RUN: begin
        pwm_en_d  = 1'b1;
        pwm_sd_d  = 1'b0;
        ss_en_d   = 1'b1;
        mppt_en_d = 1'b1;
      end
      default: begin
        pwm_en_d  = 1'b0;
        pwm_sd_d  = 1'b1;
        ss_en_d   = 1'b0;
        mppt_en_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      retry_q   <= 3'd0;
      code_q    <= FAULT_NONE;
      pwm_en_q  <= 1'b0;
      pwm_sd_q  <= 1'b1;
      ss_en_q   <= 1'b0;
      mppt_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      code_q    <= code_d;
      pwm_en_q  <= pwm_en_d;
      pwm_sd_q  <= pwm_sd_d;
      ss_en_q   <= ss_en_d;
      mppt_en_q <= mppt_en_d;
    end
  end

  assign state             = state_q;
  assign fault_code        = code_q;
  assign retry_count       = retry_q;
  assign pwm_enable        = pwm_en_q;
  assign pwm_shutdown      = pwm_sd_q;
  assign soft_start_enable = ss_en_q;
  assign mppt_enable       = mppt_en_q;

endmodule
